// File: rtl/inst_fetch.sv
// Instruction fetch: BOOT/FETCH/HOLD FSM, one-entry skid buffer, branch redirect.
// One cycle from imem_ready to inst_valid; stall holds outputs, redirect beats stall.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [7:0]            imem_rdata,
  input  logic                  imem_ready,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [7:0]            inst,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  inst_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   pc_d;
  logic                    imem_req_q;
  logic [7:0]              inst_q;
  logic [ADDR_WIDTH-1:0]   pc_out_q;
  logic                    inst_valid_q;
  logic                    skid_vld_q;
  logic [7:0]              skid_inst_q;
  logic [ADDR_WIDTH-1:0]   skid_pc_q;

  // Sequential increment wraps naturally at 2^ADDR_WIDTH.
  assign pc_d = pc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      inst_q       <= 8'h00;
      pc_out_q     <= RESET_PC;
      inst_valid_q <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_inst_q  <= 8'h00;
      skid_pc_q    <= RESET_PC;
    end else if (branch_taken) begin
      // Redirect abandons the outstanding fetch and any skid entry.
      state_q      <= FETCH;
      pc_q         <= branch_target;
      imem_req_q   <= 1'b1;
      inst_valid_q <= 1'b0;
      skid_vld_q   <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
          if (!stall) inst_valid_q <= 1'b0;
        end
        FETCH: begin
          if (imem_ready) begin
            pc_q <= pc_d;
            if (stall) begin
              state_q     <= HOLD;
              imem_req_q  <= 1'b0;
              skid_vld_q  <= 1'b1;
              skid_inst_q <= imem_rdata;
              skid_pc_q   <= pc_q;
            end else begin
              inst_q       <= imem_rdata;
              pc_out_q     <= pc_q;
              inst_valid_q <= 1'b1;
            end
          end else if (!stall) begin
            inst_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            state_q      <= FETCH;
            imem_req_q   <= 1'b1;
            skid_vld_q   <= 1'b0;
            inst_q       <= skid_inst_q;
            pc_out_q     <= skid_pc_q;
            inst_valid_q <= skid_vld_q;
          end
        end
        default: begin
          state_q    <= BOOT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign pc_out     = pc_out_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory returns addr+8'h10; expected (pc_out, inst) pairs are queued
// by the stimulus and checked by an independent monitor on every newly delivered instruction.
module tb_inst_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_ready;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] inst;
  logic [7:0] pc_out;
  logic       inst_valid;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 8'h10;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .inst         (inst),
    .pc_out       (pc_out),
    .inst_valid   (inst_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] pc, input logic [7:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  // Monitor: a new instruction is delivered when inst_valid is high after an unstalled edge.
  initial begin
    logic        stall_s;
    logic [15:0] e;
    forever begin
      @(posedge clk);
      stall_s = stall;
      @(negedge clk);
      if (inst_valid === 1'b1 && stall_s === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_inst: got pc=%0h inst=%0h expected none", pc_out, inst);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc_out", {24'h0, pc_out}, {24'h0, e[15:8]});
          chk("sb_inst",   {24'h0, inst},   {24'h0, e[7:0]});
        end
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", {24'h0, inst}, 32'h00);
    chk("rst_pc_out", {24'h0, pc_out}, 32'h00);
    chk("rst_req", {31'h0, imem_req}, 32'h0);

    rst = 1'b1;
    tick();
    chk("boot_done_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", {24'h0, imem_addr}, 32'h00);
    push(8'h00, 8'h10); push(8'h01, 8'h11); push(8'h02, 8'h12);
    tick(); tick(); tick();

    stall = 1'b1;
    tick();
    chk("stall_inst", {24'h0, inst}, 32'h12);
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("stall_valid", {31'h0, inst_valid}, 32'h1);
    tick();
    chk("stall_inst2", {24'h0, inst}, 32'h12);
    stall = 1'b0;
    push(8'h03, 8'h13);
    tick();
    chk("after_hold_addr", {24'h0, imem_addr}, 32'h04);
    chk("after_hold_req", {31'h0, imem_req}, 32'h1);
    push(8'h04, 8'h14);
    tick();

    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_valid", {31'h0, inst_valid}, 32'h0);
      chk("wait_addr", {24'h0, imem_addr}, 32'h05);
    end
    imem_ready = 1'b1;
    push(8'h05, 8'h15);
    tick();
    chk("ready_valid", {31'h0, inst_valid}, 32'h1);

    stall = 1'b1;
    tick();
    chk("skid_req", {31'h0, imem_req}, 32'h0);
    branch_taken = 1'b1; branch_target = 8'h40;
    tick();
    chk("br_valid", {31'h0, inst_valid}, 32'h0);
    chk("br_addr", {24'h0, imem_addr}, 32'h40);
    chk("br_req", {31'h0, imem_req}, 32'h1);
    branch_taken = 1'b0; stall = 1'b0;
    push(8'h40, 8'h50);
    tick();

    branch_taken = 1'b1; branch_target = 8'hFE;
    tick();
    chk("br2_valid", {31'h0, inst_valid}, 32'h0);
    chk("br2_addr", {24'h0, imem_addr}, 32'hFE);
    branch_taken = 1'b0;
    push(8'hFE, 8'h0E); push(8'hFF, 8'h0F); push(8'h00, 8'h10); push(8'h01, 8'h11);
    tick(); tick(); tick(); tick();

    stall = 1'b1;
    tick();
    chk("skid2_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("mid_rst_inst", {24'h0, inst}, 32'h00);
    chk("mid_rst_pc_out", {24'h0, pc_out}, 32'h00);
    chk("mid_rst_addr", {24'h0, imem_addr}, 32'h00);
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b1; stall = 1'b0;
    tick();
    chk("reboot_req", {31'h0, imem_req}, 32'h1);
    chk("reboot_valid", {31'h0, inst_valid}, 32'h0);
    push(8'h00, 8'h10);
    tick();
    imem_ready = 1'b0;
    tick(); tick(); tick();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
